// File: rtl/ec_point_add_dbl.sv
// Affine short-Weierstrass point add/double over GF(P_MOD): one bit-serial multiplier plus one binary-Euclid inverter, sequenced by an FSM.
// Define POINT_ADD_DOUBLE_EN to build the doubling path; without it, P == Q (finite, Py != 0) completes with err = 1.
module ec_point_add_dbl #(
  parameter int unsigned      WIDTH  = 256,
  parameter logic [WIDTH-1:0] P_MOD  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
  parameter logic [WIDTH-1:0] A_COEF = '0
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Px,
  input  logic [WIDTH-1:0] Py,
  input  logic [WIDTH-1:0] Qx,
  input  logic [WIDTH-1:0] Qy,
  input  logic             Pinf,
  input  logic             Qinf,
  output logic             busy,
  output logic             Done,
  output logic [WIDTH-1:0] Rx,
  output logic [WIDTH-1:0] Ry,
  output logic             Rinf,
  output logic             err
);

  typedef logic [WIDTH-1:0] fe_t;
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_X2, S_INV, S_MUL_S, S_MUL_S2, S_MUL_Y, S_FIN
  } state_e;

  localparam int unsigned    CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);
  localparam logic [WIDTH:0] P_EXT    = {1'b0, P_MOD};

  function automatic fe_t mod_add(input fe_t a, input fe_t b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= P_EXT) s = s - P_EXT;
    return s[WIDTH-1:0];
  endfunction

  function automatic fe_t mod_sub(input fe_t a, input fe_t b);
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + P_EXT;
    return d[WIDTH-1:0];
  endfunction

  // Division by two mod P: odd values get +P first so the shift is exact.
  function automatic fe_t mod_half(input fe_t a);
    logic [WIDTH:0] s;
    s = a[0] ? ({1'b0, a} + P_EXT) : {1'b0, a};
    return s[WIDTH:1];
  endfunction

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, rinf_q, err_q;
  fe_t           rx_q, ry_q;

  fe_t  px_q, py_q, qx_q, qy_q;
  logic pinf_q, qinf_q;
  fe_t  num_q, s_q, rxs_q;
  fe_t  u_q, v_q, x1_q, x2_q;
  fe_t  mul_a_q, mul_b_q, acc_q;

  // Multiplier step: acc = 2*acc + (msb(b) ? a : 0), reduced after each add.
  logic [WIDTH:0] mul_dbl, mul_sum;
  fe_t            acc_next;
  logic           mul_last;

  always_comb begin
    mul_dbl = {acc_q, 1'b0};
    if (mul_dbl >= P_EXT) mul_dbl = mul_dbl - P_EXT;
    mul_sum = mul_dbl + (mul_b_q[WIDTH-1] ? {1'b0, mul_a_q} : '0);
    if (mul_sum >= P_EXT) mul_sum = mul_sum - P_EXT;
    acc_next = mul_sum[WIDTH-1:0];
    mul_last = (cnt_q == CNT_LAST);
  end

  fe_t op_a, op_b;

  always_comb begin
    op_a = s_q;
    op_b = s_q;
    case (state_q)
`ifdef POINT_ADD_DOUBLE_EN
      S_X2:    begin op_a = px_q;  op_b = px_q; end
`endif
      S_MUL_S: begin op_a = num_q; op_b = s_q;  end
      S_MUL_Y: begin op_a = s_q;   op_b = mod_sub(px_q, rxs_q); end
      default: ;
    endcase
  end

  // Inverter step: one halving, or a subtract-and-halve when both are odd, so u*v at least halves per cycle.
  fe_t  u_n, v_n, x1_n, x2_n, inv_res;
  logic inv_done;

  always_comb begin
    u_n  = u_q;
    v_n  = v_q;
    x1_n = x1_q;
    x2_n = x2_q;
    if (!u_q[0]) begin
      u_n  = u_q >> 1;
      x1_n = mod_half(x1_q);
    end else if (!v_q[0]) begin
      v_n  = v_q >> 1;
      x2_n = mod_half(x2_q);
    end else if (u_q >= v_q) begin
      u_n  = (u_q - v_q) >> 1;
      x1_n = mod_half(mod_sub(x1_q, x2_q));
    end else begin
      v_n  = (v_q - u_q) >> 1;
      x2_n = mod_half(mod_sub(x2_q, x1_q));
    end
    inv_done = (u_q == fe_t'(1)) || (v_q == fe_t'(1));
    inv_res  = (u_q == fe_t'(1)) ? x1_q : x2_q;
  end

  logic chk_fin, chk_rinf, chk_err;
  fe_t  chk_rx, chk_ry;
`ifdef POINT_ADD_DOUBLE_EN
  logic chk_dbl;
`endif

  always_comb begin
    chk_fin  = 1'b1;
    chk_rinf = 1'b0;
    chk_err  = 1'b0;
    chk_rx   = '0;
    chk_ry   = '0;
`ifdef POINT_ADD_DOUBLE_EN
    chk_dbl  = 1'b0;
`endif
    if (pinf_q && qinf_q) begin
      chk_rinf = 1'b1;
    end else if (pinf_q) begin
      chk_rx = qx_q;
      chk_ry = qy_q;
    end else if (qinf_q) begin
      chk_rx = px_q;
      chk_ry = py_q;
    end else if (px_q == qx_q && (py_q != qy_q || py_q == '0)) begin
      chk_rinf = 1'b1;
    end else if (px_q == qx_q) begin
`ifdef POINT_ADD_DOUBLE_EN
      chk_fin = 1'b0;
      chk_dbl = 1'b1;
`else
      chk_rinf = 1'b1;
      chk_err  = 1'b1;
`endif
    end else begin
      chk_fin = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rinf_q  <= 1'b0;
      err_q   <= 1'b0;
      rx_q    <= '0;
      ry_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_CHECK;
          busy_q  <= 1'b1;
        end
        S_CHECK: begin
          cnt_q <= '0;
          if (chk_fin) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            rinf_q  <= chk_rinf;
            err_q   <= chk_err;
            rx_q    <= chk_rx;
            ry_q    <= chk_ry;
`ifdef POINT_ADD_DOUBLE_EN
          end else if (chk_dbl) begin
            state_q <= S_X2;
`endif
          end else begin
            state_q <= S_INV;
          end
        end
`ifdef POINT_ADD_DOUBLE_EN
        S_X2: begin
          cnt_q <= cnt_q + 1'b1;
          if (mul_last) begin
            cnt_q   <= '0;
            state_q <= S_INV;
          end
        end
`endif
        S_INV: if (inv_done) state_q <= S_MUL_S;
        S_MUL_S, S_MUL_S2: begin
          cnt_q <= cnt_q + 1'b1;
          if (mul_last) begin
            cnt_q   <= '0;
            state_q <= (state_q == S_MUL_S) ? S_MUL_S2 : S_MUL_Y;
          end
        end
        S_MUL_Y: begin
          cnt_q <= cnt_q + 1'b1;
          if (mul_last) begin
            cnt_q   <= '0;
            state_q <= S_FIN;
            done_q  <= 1'b1;
            rinf_q  <= 1'b0;
            err_q   <= 1'b0;
            rx_q    <= rxs_q;
            ry_q    <= mod_sub(acc_next, py_q);
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; every one is written before it is read in any operation.
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: if (start) begin
        px_q   <= Px;
        py_q   <= Py;
        qx_q   <= Qx;
        qy_q   <= Qy;
        pinf_q <= Pinf;
        qinf_q <= Qinf;
      end
      S_CHECK: begin
        num_q <= mod_sub(py_q, qy_q);
        u_q   <= mod_sub(px_q, qx_q);
        v_q   <= P_MOD;
        x1_q  <= fe_t'(1);
        x2_q  <= '0;
      end
      S_INV: begin
        if (inv_done) begin
          s_q <= inv_res;
        end else begin
          u_q  <= u_n;
          v_q  <= v_n;
          x1_q <= x1_n;
          x2_q <= x2_n;
        end
      end
      S_X2, S_MUL_S, S_MUL_S2, S_MUL_Y: begin
        if (cnt_q == '0) begin
          mul_a_q <= op_a;
          mul_b_q <= op_b;
          acc_q   <= '0;
        end else begin
          acc_q   <= acc_next;
          mul_b_q <= mul_b_q << 1;
        end
        if (mul_last) begin
          case (state_q)
`ifdef POINT_ADD_DOUBLE_EN
            S_X2: begin
              num_q <= mod_add(mod_add(mod_add(acc_next, acc_next), acc_next), A_COEF);
              u_q   <= mod_add(py_q, py_q);
            end
`endif
            S_MUL_S:  s_q   <= acc_next;
            S_MUL_S2: rxs_q <= mod_sub(mod_sub(acc_next, px_q), qx_q);
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign Done = done_q;
  assign Rx   = rx_q;
  assign Ry   = ry_q;
  assign Rinf = rinf_q;
  assign err  = err_q;

endmodule
